// File: rtl/dsd_pkg.sv
// Shared definitions for the serial datapath blocks.
//   - state_e       : controller state encoding (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH : default operand width for the serial subtractor
package dsd_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : dsd_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
// Ports:
//   a, b  : minuend / subtrahend bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out (set when a < b + bin)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for one bit slice.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, D = A - B mod 2^WIDTH, LSB first.
// One full-subtractor slice with a registered borrow processes one bit per
// clock; the result and borrow are published only on the completion edge.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : request, sampled only while not busy (IDLE or DONE)
//   A, B       : operands, captured on the accepted start edge
//   D          : registered difference
//   borrow_out : registered, 1 when A < B
//   busy       : 1 while a subtraction is in progress
//   done       : one-cycle pulse when D / borrow_out update
module serial_subtractor
    import dsd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    // Counter width; guard keeps it at least one bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_s;
    logic             diff_bit_s;
    logic             bout_s;

    full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (diff_bit_s),
        .bout (bout_s)
    );

    // A request is taken only when no subtraction is running.
    always_comb begin
        accept_s = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
                else       state_d = IDLE;
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) state_d = DONE;
                else                   state_d = SHIFT;
            end
            DONE: begin
                if (start) state_d = SHIFT;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the next state so they come straight off flops.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            IDLE:    begin busy_d = 1'b0; done_d = 1'b0; end
            SHIFT:   begin busy_d = 1'b1; done_d = 1'b0; end
            DONE:    begin busy_d = 1'b0; done_d = 1'b1; end
            default: begin busy_d = 1'b0; done_d = 1'b0; end
        endcase
    end

    // Datapath: operand capture, serial shift, and result publication.
    always_comb begin
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        r_sr_d       = r_sr_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        d_d          = d_q;
        borrow_out_d = borrow_out_q;
        if (accept_s) begin
            a_sr_d   = A;
            b_sr_d   = B;
            r_sr_d   = '0;
            borrow_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == SHIFT) begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            r_sr_d   = {diff_bit_s, r_sr_q[WIDTH-1:1]};
            borrow_d = bout_s;
            // Last bit: publish the full word including this edge's bit.
            if (cnt_q == CNT_LAST) begin
                cnt_d        = cnt_q;
                d_d          = {diff_bit_s, r_sr_q[WIDTH-1:1]};
                borrow_out_d = bout_s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            r_sr_q       <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            d_q          <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            r_sr_q       <= r_sr_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            d_q          <= d_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign D          = d_q;
    assign borrow_out = borrow_out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, busy4, done4, bo4;
    logic [3:0] a4, b4, d4;
    logic       start8, busy8, done8, bo8;
    logic [7:0] a8, b8, d8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .D(d4), .borrow_out(bo4), .busy(busy4), .done(done4)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .D(d8), .borrow_out(bo8), .busy(busy8), .done(done8)
    );

    // Reference ripple-carry adder, bit by bit.
    function automatic logic [7:0] ripple_add8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] s;
        logic c;
        c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return s;
    endfunction

    // Present operands with start for one edge; returns #1 after the accept edge.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Waits for done4 (bounded); lat = edges after the accept edge.
    task automatic wait_done4(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done4) return;
        end
        lat = -1;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done8) return;
        end
        lat = -1;
    endtask

    // One full operation on the 4-bit unit, checked against A - B.
    task automatic run_check4(input string name, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] exp_d, input logic exp_bo);
        int lat;
        issue4(a, b);
        wait_done4(lat);
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected 4", name, lat);
        end
        vectors++;
        if (d4 !== exp_d || bo4 !== exp_bo) begin
            miscompares++;
            $display("FAIL %s result: got D=%b borrow=%b expected D=%b borrow=%b",
                     name, d4, bo4, exp_d, exp_bo);
        end
    endtask

    task automatic test_reset;
        vectors++;
        if (d4 !== 4'd0 || bo4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got D=%b bo=%b busy=%b done=%b expected all zero",
                     d4, bo4, busy4, done4);
        end
        // Leave a non-zero result behind so clearing is observable.
        run_check4("pre_reset", 4'b1100, 4'b0010, 4'b1010, 1'b0);
        issue4(4'b0001, 4'b0110);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (d4 !== 4'd0 || bo4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got D=%b bo=%b busy=%b done=%b expected all zero",
                     d4, bo4, busy4, done4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // The discarded operation must not resume.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (busy4 !== 1'b0 || done4 !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy4, done4);
            end
        end
        run_check4("after_reset", 4'b0101, 4'b0011, 4'b0010, 1'b0);
    endtask

    task automatic test_directed;
        logic [3:0] ta [5] = '{4'b0010, 4'b0110, 4'b0011, 4'b0101, 4'b1100};
        logic [3:0] tb [5] = '{4'b1100, 4'b1001, 4'b1001, 4'b0101, 4'b0010};
        logic [3:0] td [5] = '{4'b0110, 4'b1101, 4'b1010, 4'b0000, 4'b1010};
        logic       tbo [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_check4($sformatf("directed%0d", i), ta[i], tb[i], td[i], tbo[i]);
        end
    endtask

    task automatic test_timing;
        logic [3:0] prev;
        prev = d4;
        issue4(4'b0110, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy4 !== 1'b1 || done4 !== 1'b0 || d4 !== prev) begin
                miscompares++;
                $display("FAIL timing_shift%0d: got busy=%b done=%b D=%b expected 1 0 %b",
                         i, busy4, done4, d4, prev);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (busy4 !== 1'b0 || done4 !== 1'b1 || d4 !== 4'b1101 || bo4 !== 1'b1) begin
            miscompares++;
            $display("FAIL timing_done: got busy=%b done=%b D=%b bo=%b expected 0 1 1101 1",
                     busy4, done4, d4, bo4);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || d4 !== 4'b1101) begin
            miscompares++;
            $display("FAIL timing_after: got busy=%b done=%b D=%b expected 0 0 1101",
                     busy4, done4, d4);
        end
    endtask

    task automatic test_ignored_start;
        int ndone;
        logic [3:0] got_d;
        logic got_bo;
        ndone = 0; got_d = '0; got_bo = 1'b0;
        issue4(4'b1011, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); start4 = 1'b1;
            @(posedge clk); #1;
        end
        start4 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                if (ndone == 0) begin got_d = d4; got_bo = bo4; end
                ndone++;
            end
        end
        vectors++;
        if (ndone !== 1) begin
            miscompares++;
            $display("FAIL ignored_start_pulses: got %0d done pulses expected 1", ndone);
        end
        vectors++;
        if (got_d !== 4'b0101 || got_bo !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start_result: got D=%b bo=%b expected 0101 0", got_d, got_bo);
        end
    endtask

    task automatic test_back_to_back;
        int dc [$];
        logic [3:0] dv [$];
        logic bv [$];
        logic busy_at5;
        busy_at5 = 1'b0;
        @(negedge clk);
        a4 = 4'b0011; b4 = 4'b0111; start4 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin a4 = 4'b1110; b4 = 4'b0100; end
            if (c == 5) begin start4 = 1'b0; busy_at5 = busy4; end
            if (done4) begin dc.push_back(c); dv.push_back(d4); bv.push_back(bo4); end
        end
        vectors++;
        if (dc.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d done pulses expected 2", dc.size());
        end else begin
            vectors++;
            if (dc[1] - dc[0] != 5 || dc[0] != 4) begin
                miscompares++;
                $display("FAIL b2b_spacing: got pulses at %0d,%0d expected 4,9", dc[0], dc[1]);
            end
            vectors++;
            if (dv[0] !== 4'(4'b0011 - 4'b0111) || bv[0] !== 1'b1 ||
                dv[1] !== 4'(4'b1110 - 4'b0100) || bv[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_results: got %b/%b %b/%b expected 1100/1 1010/0",
                         dv[0], bv[0], dv[1], bv[1]);
            end
        end
        vectors++;
        if (busy_at5 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept_in_done: got busy=%b expected 1", busy_at5);
        end
    endtask

    task automatic test_random8;
        logic [7:0] a, b;
        int lat;
        for (int n = 0; n < 220; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            if (n == 0) begin a = 8'd0;   b = 8'd255; end
            if (n == 1) begin a = 8'd255; b = 8'd0;   end
            if (n == 2) begin a = 8'd77;  b = 8'd77;  end
            issue8(a, b);
            wait_done8(lat);
            vectors++;
            if (lat !== 8) begin
                miscompares++;
                $display("FAIL rand8_latency: got %0d expected 8 (A=%0d B=%0d)", lat, a, b);
            end
            vectors++;
            if (ripple_add8(d8, b) !== a || d8 !== 8'(a - b)) begin
                miscompares++;
                $display("FAIL rand8_diff: got D=%0d expected %0d (A=%0d B=%0d)",
                         d8, 8'(a - b), a, b);
            end
            vectors++;
            if (bo8 !== (a < b)) begin
                miscompares++;
                $display("FAIL rand8_borrow: got %b expected %b (A=%0d B=%0d)", bo8, (a < b), a, b);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_timing();
        test_ignored_start();
        test_back_to_back();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_subtractor
